mac_issue_ctrl: RTL

MAC_ISSUE_CTRL -- requirements
Module: mac_issue_ctrl

---
 rtl/mac_issue_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/mac_issue_ctrl.sv
// MAC issue controller: shadows the MAC pipeline to detect RAW, WAW and
// accumulator hazards, and arbitrates the shared register-file write port.
module mac_issue_ctrl #(
    parameter int MAC_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             dec_valid,
    input  logic             dec_is_mac,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic             alu_wb_valid,
    output logic             dec_ready,
    output logic             mac_issue,
    output logic             wb_sel_mac,
    output logic             alu_wb_ready,
    output logic             mac_busy,
    output logic [2:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [MAC_DEPTH-1:0] valid_q, valid_d;
    logic [4:0]           rd_q [MAC_DEPTH];
    logic [4:0]           rd_d [MAC_DEPTH];
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    logic raw_haz, waw_haz, acc_haz;

    // Hazard detection over every valid shadow entry, including the retiring one.
    always_comb begin
        raw_haz   = 1'b0;
        waw_haz   = 1'b0;
        occupancy = 3'd0;
        for (int i = 0; i < MAC_DEPTH; i++) begin
            if (valid_q[i]) begin
                occupancy = occupancy + 3'd1;
                if (rd_q[i] != 5'd0) begin
                    if (dec_uses_rs1 && (dec_rs1 == rd_q[i])) raw_haz = 1'b1;
                    if (dec_uses_rs2 && (dec_rs2 == rd_q[i])) raw_haz = 1'b1;
                    if (!dec_is_mac && (dec_rd == rd_q[i]))   waw_haz = 1'b1;
                end
            end
        end
        acc_haz      = dec_is_mac & (|valid_q);
        mac_busy     = |valid_q;
        dec_ready    = ~rst & dec_valid & ~freeze & ~(raw_haz | waw_haz | acc_haz);
        mac_issue    = dec_ready & dec_is_mac;
        wb_sel_mac   = valid_q[MAC_DEPTH-1] & ~freeze;
        alu_wb_ready = ~rst & alu_wb_valid & ~freeze & ~wb_sel_mac;
        stall_cnt    = stall_cnt_q;
    end

    // Shadow shift and saturating stall counter; freeze holds everything.
    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            for (int i = 1; i < MAC_DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
            end
            valid_d[0] = mac_issue;
            rd_d[0]    = mac_issue ? dec_rd : 5'd0;
            if (dec_valid && !dec_ready && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < MAC_DEPTH; i++) rd_q[i] <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < MAC_DEPTH; i++) rd_q[i] <= rd_d[i];
        end
    end

endmodule
